// File: rtl/pixel_writer.sv
// pixel_writer: buffers pipeline pixels in a small FIFO and streams them to a frame buffer,
// swapping frames on vs. Build option FRAME_DOUBLE_BUF_EN enables ping-pong write/display buffers.
module pixel_writer #(
  parameter int H_DISP     = 1280,
  parameter int V_DISP     = 720,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  input  logic [19:0] pix_addr,
  input  logic [15:0] pix_data,
  input  logic        vs,
  output logic        next_en,
  output logic        wr_req,
  output logic [20:0] wr_addr,
  output logic [15:0] wr_data,
  input  logic        wr_ack,
  output logic        buf_sel,
  output logic [7:0]  frame_cnt,
  output logic        overflow,
  output logic        range_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(H_DISP * V_DISP);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_SWAP  = 2'd3;

  logic [35:0]      mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_r;
  logic [PTR_W-1:0] rptr_r;
  logic [PTR_W-1:0] head_idx_s;
  logic [35:0]      head_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nx_s;
  logic [1:0]       state_r;
  logic [1:0]       state_nx_s;
  logic             in_range_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic             more_s;
  logic             load_s;
  logic             req_nx_s;
  logic             swap_s;
  logic             vs_d_r;
  logic             vs_edge_s;
  logic             swap_pend_r;
  logic             wbuf_s;
  logic             next_en_r;
  logic             wr_req_r;
  logic [20:0]      wr_addr_r;
  logic [15:0]      wr_data_r;
  logic [7:0]       frame_cnt_r;
  logic             overflow_r;
  logic             range_err_r;

  assign in_range_s = ({12'd0, pix_addr} < ADDR_LIMIT);
  assign full_s     = (count_r == CNT_FULL);
  assign push_s     = pix_valid & in_range_s & ~full_s;
  // The head stays in the FIFO while requested; it is only released by the ack.
  assign pop_s      = wr_req_r & wr_ack;
  assign more_s     = (count_r > CNT_ONE);
  assign head_idx_s = pop_s ? (rptr_r + PTR_W'(1)) : rptr_r;
  assign head_s     = mem_r[head_idx_s];
  assign vs_edge_s  = vs & ~vs_d_r;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nx_s = count_r;
    if (push_s && !pop_s) begin
      count_nx_s = count_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_nx_s = count_r - CNT_ONE;
    end else begin
      count_nx_s = count_r;
    end
  end

  // Write FSM next-state, request and head-load decisions.
  always_comb begin
    state_nx_s = state_r;
    req_nx_s   = wr_req_r;
    load_s     = 1'b0;
    swap_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        req_nx_s = 1'b0;
        if (swap_pend_r) begin
          state_nx_s = ST_DRAIN;
        end else if (count_r != CNT_ZERO) begin
          load_s     = 1'b1;
          req_nx_s   = 1'b1;
          state_nx_s = ST_WRITE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (pop_s) begin
          load_s   = more_s;
          req_nx_s = more_s;
          if (swap_pend_r) begin
            state_nx_s = ST_DRAIN;
          end else if (more_s) begin
            state_nx_s = ST_WRITE;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end else begin
          req_nx_s   = 1'b1;
          state_nx_s = ST_WRITE;
        end
      end
      ST_DRAIN: begin
        if (wr_req_r) begin
          if (pop_s) begin
            load_s   = more_s;
            req_nx_s = more_s;
          end else begin
            req_nx_s = 1'b1;
          end
          state_nx_s = ST_DRAIN;
        end else if (count_r != CNT_ZERO) begin
          load_s     = 1'b1;
          req_nx_s   = 1'b1;
          state_nx_s = ST_DRAIN;
        end else begin
          req_nx_s   = 1'b0;
          state_nx_s = ST_SWAP;
        end
      end
      ST_SWAP: begin
        swap_s     = 1'b1;
        req_nx_s   = 1'b0;
        state_nx_s = ST_IDLE;
      end
      default: begin
        req_nx_s   = 1'b0;
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // FIFO storage; validity is defined by the pointers, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wptr_r] <= {pix_addr, pix_data};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_W'(1);
      end
      count_r <= count_nx_s;
    end
  end

  // FSM state and registered write-port / backpressure outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      wr_req_r  <= 1'b0;
      wr_addr_r <= 21'd0;
      wr_data_r <= 16'd0;
      next_en_r <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      wr_req_r <= req_nx_s;
      if (load_s) begin
        wr_addr_r <= {wbuf_s, head_s[35:16]};
        wr_data_r <= head_s[15:0];
      end
      // One slot of margin covers the producer's reaction latency.
      next_en_r <= (count_nx_s < CNT_HIGH) &&
                   ((state_nx_s == ST_IDLE) || (state_nx_s == ST_WRITE));
    end
  end

  // End-of-frame detection and completed-frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d_r      <= 1'b0;
      swap_pend_r <= 1'b0;
      frame_cnt_r <= 8'd0;
    end else begin
      vs_d_r <= vs;
      if (swap_s) begin
        swap_pend_r <= 1'b0;
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end else if (vs_edge_s && ((state_r == ST_IDLE) || (state_r == ST_WRITE))) begin
        swap_pend_r <= 1'b1;
      end
    end
  end

  // Sticky drop indicators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      range_err_r <= 1'b0;
    end else begin
      if (pix_valid && in_range_s && full_s) begin
        overflow_r <= 1'b1;
      end
      if (pix_valid && !in_range_s) begin
        range_err_r <= 1'b1;
      end
    end
  end

`ifdef FRAME_DOUBLE_BUF_EN
  logic wbuf_r;
  logic buf_sel_r;

  // Ping-pong select: display always reads the buffer not being written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbuf_r    <= 1'b0;
      buf_sel_r <= 1'b1;
    end else if (swap_s) begin
      wbuf_r    <= ~wbuf_r;
      buf_sel_r <= wbuf_r;
    end
  end

  assign wbuf_s  = wbuf_r;
  assign buf_sel = buf_sel_r;
`else
  assign wbuf_s  = 1'b0;
  assign buf_sel = 1'b0;
`endif

  assign next_en   = next_en_r;
  assign wr_req    = wr_req_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign frame_cnt = frame_cnt_r;
  assign overflow  = overflow_r;
  assign range_err = range_err_r;

endmodule

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer: directed stimulus with a scoreboard of expected frame-buffer writes.
module tb_pixel_writer;

`ifdef FRAME_DOUBLE_BUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_valid;
  logic [19:0] pix_addr;
  logic [15:0] pix_data;
  logic        vs;
  logic        next_en;
  logic        wr_req;
  logic [20:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        buf_sel;
  logic [7:0]  frame_cnt;
  logic        overflow;
  logic        range_err;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [35:0] sb[$];
  int          wr_cnt = 0;
  int          run_cur = 0;
  int          run_max = 0;
  logic        exp_wbuf = 1'b0;
  logic [20:0] last_addr = 21'd0;

  always #5 clk = ~clk;

  pixel_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_valid (pix_valid),
    .pix_addr  (pix_addr),
    .pix_data  (pix_data),
    .vs        (vs),
    .next_en   (next_en),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .buf_sel   (buf_sel),
    .frame_cnt (frame_cnt),
    .overflow  (overflow),
    .range_err (range_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] pdata(input logic [19:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic drive_pix(input logic [19:0] a, input bit accept);
    pix_valid = 1'b1;
    pix_addr  = a;
    pix_data  = pdata(a);
    if (accept) sb.push_back({a, pdata(a)});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Handshake monitor: every accepted write is popped from the scoreboard and compared.
  always @(negedge clk) begin
    logic [35:0] e;
    if (rst_n && wr_req) begin
      run_cur <= run_cur + 1;
      if (run_cur + 1 > run_max) run_max <= run_cur + 1;
    end else begin
      run_cur <= 0;
    end
    if (rst_n && wr_req && wr_ack) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= wr_addr;
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_write: observed addr %0h expected no write", wr_addr);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("wr_addr", {11'd0, wr_addr}, {11'd0, exp_wbuf, e[35:16]});
        check("wr_data", {16'd0, wr_data}, {16'd0, e[15:0]});
      end
    end
  end

  initial begin
    int base;
    int k;
    rst_n = 1'b0; pix_valid = 1'b0; pix_addr = 20'd0; pix_data = 16'd0;
    vs = 1'b0; wr_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_next_en",   32'(next_en),   32'd0);
    check("rst_wr_req",    32'(wr_req),    32'd0);
    check("rst_wr_addr",   32'(wr_addr),   32'd0);
    check("rst_wr_data",   32'(wr_data),   32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    check("rst_range_err", 32'(range_err), 32'd0);
    check("rst_buf_sel",   32'(buf_sel),   32'(DBL));
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("next_en_pre",  32'(next_en), 32'd0);
    @(negedge clk);
    check("next_en_rise", 32'(next_en), 32'd1);

    // Back-to-back writes with ack tied high.
    @(posedge clk); #1;
    wr_ack = 1'b1; run_max = 0; base = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      drive_pix(20'(i), 1'b1);
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    tick(8);
    @(negedge clk);
    check("b2b_writes",   32'(wr_cnt - base), 32'd4);
    check("b2b_run",      32'(run_max),       32'd4);
    check("b2b_overflow", 32'(overflow),      32'd0);
    check("b2b_sb_empty", 32'(sb.size()),     32'd0);

    // Out-of-range drop, then the last legal address.
    @(posedge clk); #1;
    base = wr_cnt;
    drive_pix(20'd921600, 1'b0);
    @(posedge clk); #1; pix_valid = 1'b0;
    tick(4);
    @(negedge clk);
    check("range_err_set",  32'(range_err),     32'd1);
    check("range_no_write", 32'(wr_cnt - base), 32'd0);
    check("range_no_ovf",   32'(overflow),      32'd0);
    @(posedge clk); #1;
    drive_pix(20'd921599, 1'b1);
    @(posedge clk); #1; pix_valid = 1'b0;
    tick(6);
    @(negedge clk);
    check("last_legal_write", 32'(wr_cnt - base),   32'd1);
    check("last_legal_addr",  32'(last_addr[19:0]), 32'd921599);

    // Fill with ack held low: backpressure and overflow.
    @(posedge clk); #1;
    wr_ack = 1'b0; base = wr_cnt;
    drive_pix(20'd100, 1'b1);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (i < 8) drive_pix(20'(101 + i), (i < 7));
      else pix_valid = 1'b0;
      @(negedge clk);
      check($sformatf("fill_next_en%0d", i),  32'(next_en),  32'(i + 1 < 7));
      check($sformatf("fill_overflow%0d", i), 32'(overflow), 32'(i == 8));
    end
    check("hold_req",  32'(wr_req),  32'd1);
    check("hold_addr", 32'(wr_addr), 32'({exp_wbuf, 20'd100}));
    check("hold_data", 32'(wr_data), 32'(pdata(20'd100)));
    tick(3);
    @(negedge clk);
    check("hold_req2",   32'(wr_req),         32'd1);
    check("hold_addr2",  32'(wr_addr),        32'({exp_wbuf, 20'd100}));
    check("hold_nowrite", 32'(wr_cnt - base), 32'd0);
    @(posedge clk); #1; wr_ack = 1'b1;
    tick(14);
    @(negedge clk);
    check("fill_drained", 32'(wr_cnt - base), 32'd8);
    check("fill_sb_empty", 32'(sb.size()),    32'd0);
    check("fill_next_en", 32'(next_en),       32'd1);

    // End of frame with three queued pixels.
    @(posedge clk); #1;
    wr_ack = 1'b0; base = wr_cnt;
    for (int i = 0; i < 3; i++) begin
      drive_pix(20'(200 + i), 1'b1);
      @(posedge clk); #1;
    end
    pix_valid = 1'b0; vs = 1'b1;
    tick(2);
    wr_ack = 1'b1;
    k = 0;
    while (frame_cnt != 8'd1 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    @(negedge clk);
    check("swap_frame_cnt",   32'(frame_cnt),     32'd1);
    check("swap_writes",      32'(wr_cnt - base), 32'd3);
    check("swap_sb_empty",    32'(sb.size()),     32'd0);
    check("swap_buf_sel",     32'(buf_sel),       32'd0);
    check("pre_swap_bit20",   32'(last_addr[20]), 32'd0);
    exp_wbuf = DBL;
    @(posedge clk); #1;
    drive_pix(20'd300, 1'b1);
    @(posedge clk); #1; pix_valid = 1'b0;
    tick(5);
    @(negedge clk);
    check("post_swap_write",  32'(wr_cnt - base), 32'd4);
    check("post_swap_bit20",  32'(last_addr[20]), 32'(DBL));
    check("single_swap",      32'(frame_cnt),     32'd1);

    // Reset in the middle of an unacknowledged request.
    @(posedge clk); #1;
    vs = 1'b0; wr_ack = 1'b0;
    drive_pix(20'd400, 1'b1);
    @(posedge clk); #1;
    drive_pix(20'd401, 1'b1);
    @(posedge clk); #1; pix_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_req", 32'(wr_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wr_req",    32'(wr_req),    32'd0);
    check("midrst_next_en",   32'(next_en),   32'd0);
    check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("midrst_overflow",  32'(overflow),  32'd0);
    check("midrst_range_err", 32'(range_err), 32'd0);
    check("midrst_buf_sel",   32'(buf_sel),   32'(DBL));
    sb.delete();
    exp_wbuf = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; wr_ack = 1'b1; base = wr_cnt;
    tick(6);
    @(negedge clk);
    check("post_rst_no_write", 32'(wr_cnt - base), 32'd0);
    check("post_rst_wr_req",   32'(wr_req),        32'd0);
    check("post_rst_next_en",  32'(next_en),       32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
